// File: rtl/vga_text_gen_pkg.sv
// Shared types and constants for the VGA text-mode generator.
package vga_text_pkg;
  localparam int         COLS_DEF   = 80;
  localparam int         ROWS_DEF   = 60;
  localparam int         ADDR_W     = 13;
  localparam logic [7:0] GLYPH_BASE = 8'h20;
  localparam logic [7:0] ASCII_MAX  = 8'h7E;
  localparam logic [7:0] LF         = 8'h0A;
  localparam logic [7:0] CR         = 8'h0D;
  localparam logic [7:0] BS         = 8'h08;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } wr_state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= GLYPH_BASE) && (c <= ASCII_MAX);
  endfunction

  function automatic logic [6:0] to_glyph(input logic [7:0] c);
    logic [7:0] g;
    g = c - GLYPH_BASE;
    return g[6:0];
  endfunction
endpackage

// File: rtl/vga_text_gen_if.sv
// Character-stream write port of the text generator (data, valid/ready, clear, busy).
interface vga_text_gen_if;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic       clear;
  logic       busy;

  modport master (output char_data, char_valid, clear, input char_ready, busy);
  modport slave  (input char_data, char_valid, clear, output char_ready, busy);
endinterface

// File: rtl/vga_text_gen_buffer_ram.sv
// Screen buffer: simple dual-port RAM, one write port, one registered read port.
module text_buffer_ram #(
  parameter int AW = 13,
  parameter int DW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  // Write port; contents are initialised by the writer's clear sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; a same-cycle write returns the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/vga_text_gen.sv
// VGA text-mode pixel generator: 80x60 glyph buffer, ASCII writer, 3-clock pixel pipeline.
// Optional underline blinking cursor enabled by defining VGA_TEXT_CURSOR_EN.
module vga_text_gen
  import vga_text_pkg::*;
#(
  parameter int COLS      = COLS_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int BLINK_CNT = 25_000_000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [9:0]     pixel_x,
  input  logic [9:0]     pixel_y,
  input  logic           video_on,
  vga_text_gen_if.slave  wr,
  output logic [9:0]     rom_addr,
  input  logic [7:0]     rom_data,
  output logic           pixel_on,
  output logic           video_on_out
);
  wr_state_e         state, state_nx;
  logic [6:0]        col, col_nx, sw_col, sw_col_nx;
  logic [5:0]        row, row_nx, sw_row, sw_row_nx;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [6:0]        wdata;
  logic [6:0]        glyph;
  logic [9:0]        x_d1, y_d1, x_d2, y_d2;
  logic              von_d1, von_d2;
  logic              cursor_hit;
  logic              unused_bits;

  function automatic logic [5:0] row_inc(input logic [5:0] r);
    return (r == 6'(ROWS - 1)) ? 6'd0 : r + 6'd1;
  endfunction

  assign wr.busy       = (state == ST_CLEAR);
  assign wr.char_ready = (state == ST_IDLE) && !wr.clear;

  // Writer state, cursor and sweep registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_CLEAR;
      col    <= 7'd0;
      row    <= 6'd0;
      sw_col <= 7'd0;
      sw_row <= 6'd0;
    end else begin
      state  <= state_nx;
      col    <= col_nx;
      row    <= row_nx;
      sw_col <= sw_col_nx;
      sw_row <= sw_row_nx;
    end
  end

  // Writer next-state: clear sweep, then one character per clock.
  always_comb begin
    state_nx  = state;
    col_nx    = col;
    row_nx    = row;
    sw_col_nx = sw_col;
    sw_row_nx = sw_row;
    we        = 1'b0;
    waddr     = {row, col};
    wdata     = 7'd0;
    case (state)
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = {sw_row, sw_col};
        if (wr.clear) begin
          sw_col_nx = 7'd0;
          sw_row_nx = 6'd0;
          col_nx    = 7'd0;
          row_nx    = 6'd0;
        end else if (sw_col == 7'(COLS - 1)) begin
          sw_col_nx = 7'd0;
          if (sw_row == 6'(ROWS - 1)) begin
            sw_row_nx = 6'd0;
            state_nx  = ST_IDLE;
          end else begin
            sw_row_nx = sw_row + 6'd1;
          end
        end else begin
          sw_col_nx = sw_col + 7'd1;
        end
      end
      ST_IDLE: begin
        if (wr.clear) begin
          state_nx  = ST_CLEAR;
          sw_col_nx = 7'd0;
          sw_row_nx = 6'd0;
          col_nx    = 7'd0;
          row_nx    = 6'd0;
        end else if (wr.char_valid) begin
          if (is_printable(wr.char_data)) begin
            we    = 1'b1;
            wdata = to_glyph(wr.char_data);
            if (col == 7'(COLS - 1)) begin
              col_nx = 7'd0;
              row_nx = row_inc(row);
            end else begin
              col_nx = col + 7'd1;
            end
          end else if (wr.char_data == LF) begin
            col_nx = 7'd0;
            row_nx = row_inc(row);
          end else if (wr.char_data == CR) begin
            col_nx = 7'd0;
          end else if ((wr.char_data == BS) && (col != 7'd0)) begin
            col_nx = col - 7'd1;
            we     = 1'b1;
            waddr  = {row, col - 7'd1};
          end else begin
            col_nx = col;
          end
        end else begin
          col_nx = col;
        end
      end
      default: begin
        state_nx = ST_CLEAR;
      end
    endcase
  end

  text_buffer_ram #(.AW(ADDR_W), .DW(7)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr ({pixel_y[8:3], pixel_x[9:3]}),
    .rdata (glyph)
  );

  assign rom_addr = {glyph, y_d1[2:0]};

`ifdef VGA_TEXT_CURSOR_EN
  logic [31:0] blink_cnt;
  logic        blink_phase;

  // Free-running blink timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= 32'd0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == 32'(BLINK_CNT - 1)) begin
      blink_cnt   <= 32'd0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 32'd1;
    end
  end

  // Underline on the bottom scanline of the cell aligned with rom_data.
  assign cursor_hit  = blink_phase && (x_d2[9:3] == col) && (y_d2[8:3] == row)
                       && (y_d2[2:0] == 3'd7);
  assign unused_bits = ^{pixel_y[9], y_d2[9]};
`else
  assign cursor_hit  = 1'b0;
  assign unused_bits = ^{pixel_y[9], x_d2[9:3], y_d2};
`endif

  // Coordinate/video delay line and registered pixel output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_d1         <= 10'd0;
      y_d1         <= 10'd0;
      von_d1       <= 1'b0;
      x_d2         <= 10'd0;
      y_d2         <= 10'd0;
      von_d2       <= 1'b0;
      pixel_on     <= 1'b0;
      video_on_out <= 1'b0;
    end else begin
      x_d1         <= pixel_x;
      y_d1         <= pixel_y;
      von_d1       <= video_on;
      x_d2         <= x_d1;
      y_d2         <= y_d1;
      von_d2       <= von_d1;
      pixel_on     <= von_d2 & (rom_data[3'd7 - x_d2[2:0]] | cursor_hit);
      video_on_out <= von_d2;
    end
  end
endmodule

// File: tb/tb_vga_text_gen.sv
// Directed self-checking bench for vga_text_gen with a registered bitmap ROM model.
module tb_vga_text_gen;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on;
  logic [9:0] rom_addr;
  logic [7:0] rom_data;
  logic       pixel_on, video_on_out;
  int         n_checks = 0;
  int         n_fail   = 0;

  vga_text_gen_if wr_if ();

  vga_text_gen #(.COLS(80), .ROWS(60), .BLINK_CNT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .video_on     (video_on),
    .wr           (wr_if),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pixel_on     (pixel_on),
    .video_on_out (video_on_out)
  );

  always #5 clk = ~clk;

  // ROM model: glyph 0 blank, glyph 1 '!', any other glyph g -> {1, g} on every row.
  function automatic logic [7:0] rom_fn(input logic [9:0] a);
    logic [6:0] g;
    logic [2:0] r;
    g = a[9:3];
    r = a[2:0];
    if (g == 7'd0) return 8'h00;
    if (g == 7'd1) return (r <= 3'd3 || r == 3'd6) ? 8'h18 : 8'h00;
    return {1'b1, g};
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic scan(input int x, input int y, output logic p);
    @(negedge clk);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = 1'b1;
    repeat (3) @(posedge clk);
    #1 p = pixel_on;
  endtask

  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    wr_if.char_data  = c;
    wr_if.char_valid = 1'b1;
    @(posedge clk);
    #1 wr_if.char_valid = 1'b0;
  endtask

  task automatic count_sweep(output int cnt);
    cnt = 0;
    while (wr_if.busy === 1'b1 && cnt < 10000) begin
      @(posedge clk);
      #1 cnt++;
    end
  endtask

  task automatic test_reset;
    int   cnt;
    logic p;
    reset = 1'b1;
    pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b0;
    wr_if.char_data = 8'h00; wr_if.char_valid = 1'b0; wr_if.clear = 1'b0;
    #2;
    n_checks++;
    if ({wr_if.char_ready, wr_if.busy, pixel_on, video_on_out, rom_addr} !== {1'b0, 1'b1, 1'b0, 1'b0, 10'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got ready=%b busy=%b pix=%b von=%b rom=%h, want 0 1 0 0 000",
               wr_if.char_ready, wr_if.busy, pixel_on, video_on_out, rom_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    count_sweep(cnt);
    n_checks++;
    if (cnt !== 4800) begin n_fail++; $display("FAIL sweep_len: got %0d want 4800", cnt); end
    n_checks++;
    if (wr_if.char_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_sweep: got %b want 1", wr_if.char_ready); end
    scan(0, 0, p);
    n_checks++;
    if (p !== 1'b0) begin n_fail++; $display("FAIL blank_0_0: got %b want 0", p); end
    scan(633, 479, p);
    n_checks++;
    if (p !== 1'b0) begin n_fail++; $display("FAIL blank_last: got %b want 0", p); end
  endtask

  task automatic test_glyph;
    logic [7:0] got, e;
    send_char(8'h21);
    for (int y = 0; y < 8; y++) begin
      got = 8'h00;
      for (int c = 0; c < 11; c++) begin
        @(negedge clk);
        if (c >= 3) got[7-(c-3)] = pixel_on;
        if (c < 8) begin
          pixel_x = 10'(c);
          pixel_y = 10'(y);
          video_on = 1'b1;
        end
      end
      e = (y <= 3 || y == 6) ? 8'h18 : 8'h00;
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL excl_row%0d: got %b want %b", y, got, e); end
    end
  endtask

  task automatic test_line_wrap;
    logic p;
    send_char(8'h0D);
    for (int i = 0; i < 80; i++) send_char(8'h30);
    scan(632, 0, p);
    n_checks++;
    if (p !== 1'b1) begin n_fail++; $display("FAIL cell_79_0: got %b want 1", p); end
    send_char(8'h0A);
    send_char(8'h08);
    send_char(8'h41);
    scan(0, 8, p);
    n_checks++;
    if (p !== 1'b0) begin n_fail++; $display("FAIL cell_0_1_blank: got %b want 0", p); end
    scan(2, 16, p);
    n_checks++;
    if (p !== 1'b1) begin n_fail++; $display("FAIL A_at_0_2: got %b want 1", p); end
    send_char(8'h41);
    send_char(8'h08);
    scan(8, 16, p);
    n_checks++;
    if (p !== 1'b0) begin n_fail++; $display("FAIL bs_erase_1_2: got %b want 0", p); end
  endtask

  task automatic test_row_wrap;
    logic p;
    send_char(8'h0D);
    for (int i = 0; i < 57; i++) send_char(8'h0A);
    send_char(8'h41);
    scan(2, 472, p);
    n_checks++;
    if (p !== 1'b1) begin n_fail++; $display("FAIL A_at_0_59: got %b want 1", p); end
    scan(2, 0, p);
    n_checks++;
    if (p !== 1'b0) begin n_fail++; $display("FAIL zero_at_0_0: got %b want 0", p); end
    send_char(8'h0D);
    send_char(8'h0A);
    send_char(8'h41);
    scan(2, 0, p);
    n_checks++;
    if (p !== 1'b1) begin n_fail++; $display("FAIL wrap_overwrite_0_0: got %b want 1", p); end
  endtask

  task automatic test_video_gate;
    logic p;
    scan(0, 0, p);
    @(negedge clk);
    n_checks++;
    if ({pixel_on, video_on_out} !== 2'b11) begin n_fail++; $display("FAIL gate_before: got %b want 11", {pixel_on, video_on_out}); end
    video_on = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pixel_on, video_on_out} !== 2'b11) begin n_fail++; $display("FAIL gate_plus2: got %b want 11", {pixel_on, video_on_out}); end
    @(negedge clk);
    n_checks++;
    if ({pixel_on, video_on_out} !== 2'b00) begin n_fail++; $display("FAIL gate_plus3: got %b want 00", {pixel_on, video_on_out}); end
  endtask

  task automatic test_cursor;
    logic        p;
    logic [15:0] s;
    int          bad;
    scan(9, 7, p);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s[i] = pixel_on;
    end
    bad = 0;
`ifdef VGA_TEXT_CURSOR_EN
    for (int i = 0; i < 12; i++) if (s[i+4] === s[i]) bad++;
`else
    for (int i = 0; i < 16; i++) if (s[i] !== 1'b0) bad++;
`endif
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL cursor_row7: got samples %b, %0d bad, want 0 bad", s, bad); end
  endtask

  task automatic test_clear;
    int   cnt;
    logic p;
    @(negedge clk);
    wr_if.clear = 1'b1; wr_if.char_valid = 1'b1; wr_if.char_data = 8'h41;
    #1;
    n_checks++;
    if (wr_if.char_ready !== 1'b0) begin n_fail++; $display("FAIL ready_on_clear: got %b want 0", wr_if.char_ready); end
    @(posedge clk);
    #1 wr_if.clear = 1'b0; wr_if.char_valid = 1'b0;
    n_checks++;
    if (wr_if.busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_clear: got %b want 1", wr_if.busy); end
    repeat (100) @(posedge clk);
    @(negedge clk);
    wr_if.clear = 1'b1;
    @(posedge clk);
    #1 wr_if.clear = 1'b0;
    count_sweep(cnt);
    n_checks++;
    if (cnt !== 4800) begin n_fail++; $display("FAIL clear_restart_len: got %0d want 4800", cnt); end
    scan(2, 0, p);
    n_checks++;
    if (p !== 1'b0) begin n_fail++; $display("FAIL cleared_0_0: got %b want 0", p); end
    send_char(8'h41);
    scan(2, 0, p);
    n_checks++;
    if (p !== 1'b1) begin n_fail++; $display("FAIL cursor_homed: got %b want 1", p); end
  endtask

  task automatic test_reset_mid;
    int cnt;
    @(negedge clk);
    wr_if.clear = 1'b1;
    @(posedge clk);
    #1 wr_if.clear = 1'b0;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({wr_if.char_ready, wr_if.busy, pixel_on, video_on_out, rom_addr} !== {1'b0, 1'b1, 1'b0, 1'b0, 10'd0}) begin
      n_fail++;
      $display("FAIL mid_reset_values: got ready=%b busy=%b pix=%b von=%b rom=%h, want 0 1 0 0 000",
               wr_if.char_ready, wr_if.busy, pixel_on, video_on_out, rom_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    count_sweep(cnt);
    n_checks++;
    if (cnt !== 4800) begin n_fail++; $display("FAIL mid_reset_sweep_len: got %0d want 4800", cnt); end
  endtask

  initial begin
    test_reset();
    test_glyph();
    test_line_wrap();
    test_row_wrap();
    test_video_gate();
    test_cursor();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
